fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline; directly upstream of the IF/ID boundary that the hazard unit controls.
- Owns the PC register and drives the instruction memory request.
- Consumes the hazard unit's pcWEN, IFID_enable and IFID_flush.
- Applies branch/jump redirects and produces the IF/ID latch contents for decode.

---
 rtl/fetch_unit.sv | 171 +++++++++++++++++
 tb/tb_fetch_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// MIPS IF stage: PC, redirect hold, optional BTB (FETCH_BTB_EN). IF/ID loads one edge after ihit+IFID_enable.
// Stalls via pcWEN/IFID_enable hold PC and latch; redirects arriving while stalled are parked until pcWEN.
module fetch_unit #(
  parameter logic [31:0] PC_INIT     = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        pcWEN,
  input  logic        IFID_enable,
  input  logic        IFID_flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  input  logic        br_update_en,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_target,
  input  logic        br_taken,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        ifid_pred_taken
);

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    REDIR_PEND = 2'd1,
    HALTED     = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        pred_taken;
  } ifid_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pend_pc, pend_nxt;
  logic [31:0] pc_plus4;
  logic        predicted;
  logic        btb_hit;
  logic [31:0] btb_target;
  ifid_t       ifid;

  // Targets are word aligned; the low two redirect bits are discarded.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign pc_plus4 = pc + 32'd4;
  assign imemaddr = pc;
  assign imemREN  = (state != HALTED);

`ifdef FETCH_BTB_EN
  localparam int IDXW = $clog2(BTB_ENTRIES);
  localparam int TAGW = 30 - IDXW;

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [31:0]     target;
  } btb_ent_t;

  btb_ent_t                btb_mem [BTB_ENTRIES];
  logic [BTB_ENTRIES-1:0]  btb_vld;
  logic [IDXW-1:0]         rd_idx, wr_idx;
  logic [TAGW-1:0]         rd_tag, wr_tag;
  logic                    wr_match;
  logic                    unused_br_bits;

  assign rd_idx         = pc[IDXW+1:2];
  assign rd_tag         = pc[31:IDXW+2];
  assign wr_idx         = br_pc[IDXW+1:2];
  assign wr_tag         = br_pc[31:IDXW+2];
  assign unused_br_bits = ^br_pc[1:0];

  assign btb_hit    = btb_vld[rd_idx] && (btb_mem[rd_idx].tag == rd_tag);
  assign btb_target = btb_mem[rd_idx].target;
  assign wr_match   = btb_vld[wr_idx] && (btb_mem[wr_idx].tag == wr_tag);

  // Lookup reads registered contents, so a same-cycle update is seen next cycle.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      btb_vld <= '0;
    end else if (br_update_en) begin
      if (br_taken) begin
        btb_vld[wr_idx] <= 1'b1;
      end else if (wr_match) begin
        btb_vld[wr_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (br_update_en && br_taken) begin
      btb_mem[wr_idx] <= '{tag: wr_tag, target: br_target};
    end
  end
`else
  logic unused_br;
  assign unused_br  = ^{br_update_en, br_pc, br_target, br_taken, (BTB_ENTRIES > 0)};
  assign btb_hit    = 1'b0;
  assign btb_target = 32'h0;
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= FETCH;
      pc      <= PC_INIT;
      pend_pc <= 32'h0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      pend_pc <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    pend_nxt  = pend_pc;
    predicted = 1'b0;
    if (halt) begin
      state_nxt = HALTED;
    end else if (state != HALTED) begin
      if (redirect_valid) begin
        if (pcWEN) begin
          pc_nxt    = {redirect_pc[31:2], 2'b00};
          state_nxt = FETCH;
        end else begin
          pend_nxt  = {redirect_pc[31:2], 2'b00};
          state_nxt = REDIR_PEND;
        end
      end else if (pcWEN) begin
        if (state == REDIR_PEND) begin
          pc_nxt    = pend_pc;
          state_nxt = FETCH;
        end else if (btb_hit) begin
          pc_nxt    = btb_target;
          predicted = 1'b1;
        end else begin
          pc_nxt    = pc_plus4;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ifid <= '0;
    end else if (IFID_flush) begin
      ifid <= '0;
    end else if (IFID_enable) begin
      if (state == HALTED) begin
        ifid <= '0;
      end else begin
        ifid <= '{instr: imemload, pc4: pc_plus4, valid: ihit, pred_taken: predicted};
      end
    end
  end

  assign ifid_instr      = ifid.instr;
  assign ifid_pc4        = ifid.pc4;
  assign ifid_valid      = ifid.valid;
  assign ifid_pred_taken = ifid.pred_taken;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit with PC_INIT=0x40; BTB expectations follow FETCH_BTB_EN.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        pcWEN;
  logic        IFID_enable;
  logic        IFID_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        br_update_en = 1'b0;
  logic [31:0] br_pc        = 32'h0;
  logic [31:0] br_target    = 32'h0;
  logic        br_taken     = 1'b0;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        ifid_pred_taken;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.PC_INIT(32'h0000_0040), .BTB_ENTRIES(8)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .pcWEN(pcWEN),
    .IFID_enable(IFID_enable), .IFID_flush(IFID_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .br_update_en(br_update_en), .br_pc(br_pc), .br_target(br_target), .br_taken(br_taken),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
    .ifid_pred_taken(ifid_pred_taken)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        nrst;
    logic        ihit;
    logic [31:0] load;
    logic        pcwen;
    logic        en;
    logic        flush;
    logic        rv;
    logic [31:0] rpc;
    logic        halt;
    logic [31:0] e_addr;
    logic        e_ren;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_pred;
  } vec_t;

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int step);
    nRST           = v.nrst;
    ihit           = v.ihit;
    imemload       = v.load;
    pcWEN          = v.pcwen;
    IFID_enable    = v.en;
    IFID_flush     = v.flush;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    halt           = v.halt;
    @(posedge CLK);
    #1;
    chk("imemaddr", step, imemaddr, v.e_addr);
    chk("imemREN", step, {31'h0, imemREN}, {31'h0, v.e_ren});
    chk("ifid_instr", step, ifid_instr, v.e_instr);
    chk("ifid_pc4", step, ifid_pc4, v.e_pc4);
    chk("ifid_valid", step, {31'h0, ifid_valid}, {31'h0, v.e_valid});
    chk("ifid_pred_taken", step, {31'h0, ifid_pred_taken}, {31'h0, v.e_pred});
  endtask

  vec_t tbl [23];
  vec_t v;
  logic [31:0] btb_next;
  logic        btb_pred;

  initial begin
    //          nrst ihit load          pcwen en flush rv rpc           halt  addr          ren instr         pc4           vld pred
    tbl[0]  = '{0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h40,       1, 32'h0,        32'h0,   0, 0};
    tbl[1]  = '{1, 1, 32'hA0000001, 1, 1, 0, 0, 32'h0,        0, 32'h44,       1, 32'hA0000001, 32'h44,  1, 0};
    tbl[2]  = '{1, 1, 32'hA0000002, 1, 1, 0, 0, 32'h0,        0, 32'h48,       1, 32'hA0000002, 32'h48,  1, 0};
    tbl[3]  = '{1, 1, 32'hA0000003, 1, 1, 0, 0, 32'h0,        0, 32'h4C,       1, 32'hA0000003, 32'h4C,  1, 0};
    tbl[4]  = '{1, 1, 32'hA0000004, 1, 1, 0, 1, 32'h100,      0, 32'h100,      1, 32'hA0000004, 32'h50,  1, 0};
    tbl[5]  = '{1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0,        0, 32'h100,      1, 32'hA0000004, 32'h50,  1, 0};
    tbl[6]  = tbl[5];
    tbl[7]  = tbl[5];
    tbl[8]  = tbl[5];
    tbl[9]  = '{1, 0, 32'h12345678, 0, 1, 0, 0, 32'h0,        0, 32'h100,      1, 32'h12345678, 32'h104, 0, 0};
    tbl[10] = '{1, 1, 32'h11111111, 1, 1, 1, 1, 32'h203,      0, 32'h200,      1, 32'h0,        32'h0,   0, 0};
    tbl[11] = '{1, 1, 32'h22222222, 1, 1, 0, 0, 32'h0,        0, 32'h204,      1, 32'h22222222, 32'h204, 1, 0};
    tbl[12] = '{1, 0, 32'h0,        0, 0, 0, 1, 32'h300,      0, 32'h204,      1, 32'h22222222, 32'h204, 1, 0};
    tbl[13] = '{1, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h204,      1, 32'h22222222, 32'h204, 1, 0};
    tbl[14] = tbl[13];
    tbl[15] = '{1, 1, 32'h33333333, 1, 1, 0, 0, 32'h0,        0, 32'h300,      1, 32'h33333333, 32'h208, 1, 0};
    tbl[16] = '{1, 1, 32'h0,        1, 0, 0, 1, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 1, 32'h33333333, 32'h208, 1, 0};
    tbl[17] = '{1, 1, 32'h44444444, 1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h44444444, 32'h0,   1, 0};
    tbl[18] = '{1, 1, 32'h55555555, 1, 1, 0, 0, 32'h0,        1, 32'h0,        0, 32'h55555555, 32'h4,   1, 0};
    tbl[19] = '{1, 1, 32'h66666666, 1, 1, 0, 1, 32'h500,      0, 32'h0,        0, 32'h0,        32'h0,   0, 0};
    tbl[20] = '{1, 0, 32'h0,        0, 0, 0, 1, 32'h600,      0, 32'h0,        0, 32'h0,        32'h0,   0, 0};
    tbl[21] = '{1, 1, 32'h0,        1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,   0, 0};
    tbl[22] = '{0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h40,       1, 32'h0,        32'h0,   0, 0};

    for (int i = 0; i < 23; i++) run(tbl[i], i);

`ifdef FETCH_BTB_EN
    btb_next = 32'h1000;
    btb_pred = 1'b1;
`else
    btb_next = 32'h84;
    btb_pred = 1'b0;
`endif

    // Train a taken branch at 0x80 while stalled at 0x40.
    br_update_en = 1'b1; br_pc = 32'h80; br_target = 32'h1000; br_taken = 1'b1;
    v = '{1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 32'h40, 1, 32'h0, 32'h0, 0, 0};
    run(v, 100);
    br_update_en = 1'b0;
    v = '{1, 0, 32'h0, 1, 0, 0, 1, 32'h80, 0, 32'h80, 1, 32'h0, 32'h0, 0, 0};
    run(v, 101);
    v = '{1, 1, 32'h77777777, 1, 1, 0, 0, 32'h0, 0, btb_next, 1, 32'h77777777, 32'h84, 1, btb_pred};
    run(v, 102);

    // Not-taken resolution removes the entry; refetching 0x80 falls through.
    br_update_en = 1'b1; br_taken = 1'b0;
    v = '{1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, btb_next, 1, 32'h77777777, 32'h84, 1, btb_pred};
    run(v, 103);
    br_update_en = 1'b0;
    v = '{1, 0, 32'h0, 1, 0, 0, 1, 32'h80, 0, 32'h80, 1, 32'h77777777, 32'h84, 1, btb_pred};
    run(v, 104);
    v = '{1, 1, 32'h88888888, 1, 1, 0, 0, 32'h0, 0, 32'h84, 1, 32'h88888888, 32'h84, 1, 0};
    run(v, 105);

    // A newer held redirect replaces the older one.
    v = '{1, 0, 32'h0, 0, 0, 0, 1, 32'h400, 0, 32'h84, 1, 32'h88888888, 32'h84, 1, 0};
    run(v, 106);
    v = '{1, 0, 32'h0, 0, 0, 0, 1, 32'h500, 0, 32'h84, 1, 32'h88888888, 32'h84, 1, 0};
    run(v, 107);
    v = '{1, 1, 32'h0, 1, 0, 0, 0, 32'h0, 0, 32'h500, 1, 32'h88888888, 32'h84, 1, 0};
    run(v, 108);
    v = '{1, 1, 32'h99999999, 1, 1, 0, 0, 32'h0, 0, 32'h504, 1, 32'h99999999, 32'h504, 1, 0};
    run(v, 109);

    // Flush without enable still clears the latch.
    v = '{1, 0, 32'h0, 0, 0, 1, 0, 32'h0, 0, 32'h504, 1, 32'h0, 32'h0, 0, 0};
    run(v, 110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
